midi_msg_tx: RTL and testbench
==============================

MIDI_MSG_TX -- requirements
Module: midi_msg_tx

Interface
REQ-001 SHALL have parameter REG_CLK_FREQUENCY, default 50_000_000, giving the reg_clk frequency in Hz.
REQ-002 SHALL have parameter MIDI_BAUD, default 31250, giving the serial bit rate.
REQ-003 SHALL have parameter Invert_txd, default 0; when 1, midi_txd is logically inverted.
REQ-004 SHALL have port reg_clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_reg, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port msg_valid, input, 1 bit: a message is offered.
REQ-007 SHALL have port msg_ready, output, 1 bit: the block can accept a message.
REQ-008 SHALL have port msg_status, input, 8 bits: MIDI status byte.
REQ-009 SHALL have port msg_data1, input, 8 bits: first data byte.
REQ-010 SHALL have port msg_data2, input, 8 bits: second data byte.
REQ-011 SHALL have port midi_txd, output, 1 bit: serial MIDI line.
REQ-012 SHALL have port busy, output, 1 bit: a frame is in progress.

Function
REQ-013 Bit period SHALL be DIV = REG_CLK_FREQUENCY/MIDI_BAUD cycles (integer, 1600 at defaults); every bit is held exactly DIV cycles.
REQ-014 Frame SHALL be 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1); consecutive bytes of one message SHALL follow with no gap.
REQ-015 FSM SHALL use states IDLE, START, DATA, STOP:
- IDLE -> START on accept.
- START -> DATA after DIV cycles.
- DATA -> STOP after 8 bits.
- STOP -> START if bytes remain, else IDLE.
REQ-016 msg_ready SHALL be 1 only in IDLE; accept = msg_valid and msg_ready on a rising edge; all three input bytes are latched at accept.
REQ-017 The start bit SHALL appear on midi_txd in the cycle after accept; msg_ready SHALL return to 1 in the cycle after the last stop bit completes.
REQ-018 Message length by status:
- 0x80-0xBF and 0xE0-0xEF: 3 bytes.
- 0xC0-0xDF: 2 bytes.
- 0xF2: 3 bytes.
- 0xF1, 0xF3: 2 bytes.
- Other 0xF0-0xFF: 1 byte.
Unused data inputs SHALL be ignored.
REQ-019 If msg_status[7]=0, the message SHALL be accepted and discarded: no frame is sent and msg_ready is 1 again the next cycle.
REQ-020 Only data bits 6:0 of msg_data1 and msg_data2 SHALL be transmitted; bit 7 is forced to 0.
REQ-021 busy SHALL be 1 in every non-IDLE state.
REQ-022 midi_txd SHALL equal the logical line value XOR Invert_txd; the idle line value is 1.

Reset
REQ-023 While reset_reg=1, the block SHALL hold IDLE with midi_txd = 1 XOR Invert_txd, busy=0, msg_ready=0, and the bit counter, divider and running-status register at 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously) and drive the line to idle; the aborted message is not resumed.
REQ-025 msg_ready SHALL become 1 on the first rising edge after reset_reg is released.

Configuration
REQ-026 Macro MIDI_RUNNING_STATUS_EN, when defined, SHALL enable running status:
- A channel message (0x80-0xEF) whose status equals the last transmitted status SHALL omit the status byte.
- 0xF0-0xF7 SHALL clear the stored status.
- 0xF8-0xFF SHALL leave the stored status unchanged.
- Reset SHALL clear the stored status.
REQ-027 Without MIDI_RUNNING_STATUS_EN, every message SHALL transmit its status byte, and no running-status register SHALL exist.

Verification
REQ-028 Note On 0x90/0x3C/0x64 from reset -> three frames, 30 bits, 48000 cycles; line bits decode to 0x90, 0x3C, 0x64 LSB first; msg_ready=0 for exactly 48000 cycles.
REQ-029 Program Change 0xC5/0x07/0xFF -> two frames (0xC5, 0x07); data2 not sent; 32000 cycles.
REQ-030 Two Note On 0x90 messages back to back -> second message is 2 frames with the macro defined, 3 frames without it.
REQ-031 0x90 message, then 0xF8, then 0x90 message (macro defined) -> 0xF8 sent as one frame; the third message omits its status; 0xF2 instead of 0xF8 -> third message sends its status.
REQ-032 reset_reg pulsed during the 4th data bit of the first byte -> midi_txd idle in the same cycle, busy=0; msg_ready=1 one edge after release; the next message starts with its status byte.
REQ-033 msg_status=0x3C with msg_valid=1 -> accepted, midi_txd stays idle, msg_ready=1 the next cycle; with Invert_txd=1, the idle line reads 0.

Source files
------------

// File: rtl/midi_msg_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | midi_msg_tx: serialises a 1-3 byte MIDI message onto a UART-style line.  |
// | Optional running status is enabled with macro MIDI_RUNNING_STATUS_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module midi_msg_tx #(
   parameter int REG_CLK_FREQUENCY = 50_000_000,
   parameter int MIDI_BAUD         = 31250,
   parameter bit Invert_txd        = 1'b0
) (
   input  logic       reg_clk,
   input  logic       reset_reg,
   input  logic       msg_valid,
   output logic       msg_ready,
   input  logic [7:0] msg_status,
   input  logic [7:0] msg_data1,
   input  logic [7:0] msg_data2,
   output logic       midi_txd,
   output logic       busy
);

   localparam int               DIV      = REG_CLK_FREQUENCY / MIDI_BAUD;
   localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [15:0]      pend_q, pend_d;
   logic [1:0]       left_q, left_d;
   logic             txd_q, txd_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
`ifdef MIDI_RUNNING_STATUS_EN
   logic [7:0]       rs_q, rs_d;
`endif

   logic [1:0]  msg_len;
   logic        skip_status;
   logic [23:0] queue;
   logic [1:0]  queue_cnt;
   logic        accept;
   logic        div_tick;
   logic        unused_bits;

   // Bit 7 of the data bytes is never transmitted.
   assign unused_bits = msg_data1[7] ^ msg_data2[7];

   assign accept   = msg_valid & ready_q;
   assign div_tick = (div_q == DIV_LAST);

   always_comb begin
      msg_len = 2'd1;
      case (msg_status[7:4])
         4'h8, 4'h9, 4'hA, 4'hB, 4'hE: msg_len = 2'd3;
         4'hC, 4'hD:                   msg_len = 2'd2;
         4'hF: begin
            case (msg_status[3:0])
               4'h2:       msg_len = 2'd3;
               4'h1, 4'h3: msg_len = 2'd2;
               default:    msg_len = 2'd1;
            endcase
         end
         default: msg_len = 2'd1;
      endcase
   end

   always_comb begin
`ifdef MIDI_RUNNING_STATUS_EN
      skip_status = (msg_status[7:4] != 4'hF) && (msg_status == rs_q);
`else
      skip_status = 1'b0;
`endif
      if (skip_status) begin
         queue     = {8'h00, 1'b0, msg_data2[6:0], 1'b0, msg_data1[6:0]};
         queue_cnt = msg_len - 2'd1;
      end else begin
         queue     = {1'b0, msg_data2[6:0], 1'b0, msg_data1[6:0], msg_status};
         queue_cnt = msg_len;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      pend_d  = pend_q;
      left_d  = left_q;
      txd_d   = txd_q;
`ifdef MIDI_RUNNING_STATUS_EN
      rs_d    = rs_q;
`endif
      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            div_d = '0;
            bit_d = 3'd0;
            // Messages without a status bit are swallowed without a frame.
            if (accept && msg_status[7]) begin
               state_d = START;
               txd_d   = 1'b0;
               shreg_d = queue[7:0];
               pend_d  = queue[23:8];
               left_d  = queue_cnt - 2'd1;
`ifdef MIDI_RUNNING_STATUS_EN
               if (msg_status[7:4] != 4'hF) begin
                  rs_d = msg_status;
               end else if (!msg_status[3]) begin
                  rs_d = 8'h00;
               end
`endif
            end
         end
         START: begin
            if (div_tick) begin
               div_d   = '0;
               bit_d   = 3'd0;
               state_d = DATA;
               txd_d   = shreg_q[0];
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         DATA: begin
            if (div_tick) begin
               div_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shreg_d = {1'b0, shreg_q[7:1]};
                  txd_d   = shreg_q[1];
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         STOP: begin
            if (div_tick) begin
               div_d = '0;
               if (left_q != 2'd0) begin
                  state_d = START;
                  txd_d   = 1'b0;
                  shreg_d = pend_q[7:0];
                  pend_d  = {8'h00, pend_q[15:8]};
                  left_d  = left_q - 2'd1;
               end else begin
                  state_d = IDLE;
                  txd_d   = 1'b1;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge reg_clk or posedge reset_reg) begin
      if (reset_reg) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= 3'd0;
         shreg_q <= 8'h00;
         pend_q  <= 16'h0000;
         left_q  <= 2'd0;
         txd_q   <= 1'b1;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
         rs_q    <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         pend_q  <= pend_d;
         left_q  <= left_d;
         txd_q   <= txd_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
`ifdef MIDI_RUNNING_STATUS_EN
         rs_q    <= rs_d;
`endif
      end
   end

   assign msg_ready = ready_q;
   assign busy      = busy_q;
   assign midi_txd  = txd_q ^ Invert_txd;

endmodule
`default_nettype wire

// File: tb/tb_midi_msg_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_midi_msg_tx: table-driven bench decoding the serial line of           |
// | midi_msg_tx for both running-status builds.                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_midi_msg_tx;

   localparam int DIV_S = 8;
   localparam int DIV_B = 1600;

   typedef struct packed {
      logic [7:0]  st;
      logic [7:0]  d1;
      logic [7:0]  d2;
      logic [2:0]  n;
      logic [23:0] eb;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       sel;
   logic       m_valid;
   logic [7:0] m_status, m_data1, m_data2;

   logic s_ready, s_txd, s_busy;
   logic i_ready, i_txd, i_busy;
   logic b_ready, b_txd, b_busy;
   logic valid_s, valid_b;
   logic line_w, rdy_w, busy_w;

   int tests = 0;
   int fails = 0;

   vec_t tbl [18];

   always #5 clk = ~clk;

   assign valid_s = m_valid & ~sel;
   assign valid_b = m_valid & sel;
   assign line_w  = sel ? b_txd   : s_txd;
   assign rdy_w   = sel ? b_ready : s_ready;
   assign busy_w  = sel ? b_busy  : s_busy;

   midi_msg_tx #(.REG_CLK_FREQUENCY(80), .MIDI_BAUD(10), .Invert_txd(1'b0)) dut_s (
      .reg_clk(clk), .reset_reg(rst), .msg_valid(valid_s), .msg_ready(s_ready),
      .msg_status(m_status), .msg_data1(m_data1), .msg_data2(m_data2),
      .midi_txd(s_txd), .busy(s_busy));

   midi_msg_tx #(.REG_CLK_FREQUENCY(80), .MIDI_BAUD(10), .Invert_txd(1'b1)) dut_i (
      .reg_clk(clk), .reset_reg(rst), .msg_valid(valid_s), .msg_ready(i_ready),
      .msg_status(m_status), .msg_data1(m_data1), .msg_data2(m_data2),
      .midi_txd(i_txd), .busy(i_busy));

   midi_msg_tx dut_b (
      .reg_clk(clk), .reset_reg(rst), .msg_valid(valid_b), .msg_ready(b_ready),
      .msg_status(m_status), .msg_data1(m_data1), .msg_data2(m_data2),
      .midi_txd(b_txd), .busy(b_busy));

   task automatic chk1(input string nm, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   task automatic chk10(input string nm, input logic [9:0] act, input logic [9:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   // Offers one message and decodes every line bit, checking each is held exactly div cycles.
   task automatic send_msg(input string nm, input logic [7:0] st, input logic [7:0] d1,
                           input logic [7:0] d2, input int n, input logic [23:0] eb, input int div);
      logic [9:0] fr;
      logic       a, hold_bad, rdy_bad, busy_bad;
      @(negedge clk);
      chk1($sformatf("%s pre_ready", nm), rdy_w, 1'b1);
      m_status = st;
      m_data1  = d1;
      m_data2  = d2;
      m_valid  = 1'b1;
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      if (n == 0) begin
         chk1($sformatf("%s discard_line", nm), line_w, 1'b1);
         chk1($sformatf("%s discard_ready", nm), rdy_w, 1'b1);
         chk1($sformatf("%s discard_busy", nm), busy_w, 1'b0);
         return;
      end
      hold_bad = 1'b0;
      rdy_bad  = 1'b0;
      busy_bad = 1'b0;
      fr       = '0;
      for (int f = 0; f < n; f++) begin
         for (int k = 0; k < 10; k++) begin
            a     = line_w;
            fr[k] = a;
            if (rdy_w !== 1'b0) rdy_bad = 1'b1;
            if (busy_w !== 1'b1) busy_bad = 1'b1;
            for (int c = 0; c < div - 1; c++) begin
               @(posedge clk);
               #1;
               if (line_w !== a) hold_bad = 1'b1;
               if (rdy_w !== 1'b0) rdy_bad = 1'b1;
               if (busy_w !== 1'b1) busy_bad = 1'b1;
            end
            @(posedge clk);
            #1;
         end
         chk10($sformatf("%s frame%0d", nm, f), fr, {1'b1, eb[8*f +: 8], 1'b0});
      end
      chk1($sformatf("%s bit_hold_bad", nm), hold_bad, 1'b0);
      chk1($sformatf("%s ready_low_bad", nm), rdy_bad, 1'b0);
      chk1($sformatf("%s busy_high_bad", nm), busy_bad, 1'b0);
      chk1($sformatf("%s end_ready", nm), rdy_w, 1'b1);
      chk1($sformatf("%s end_busy", nm), busy_w, 1'b0);
      chk1($sformatf("%s end_line", nm), line_w, 1'b1);
   endtask

   initial begin
      tbl[0]  = '{st: 8'h90, d1: 8'h3C, d2: 8'h64, n: 3'd3, eb: 24'h643C90};
      tbl[1]  = '{st: 8'hC5, d1: 8'h07, d2: 8'hFF, n: 3'd2, eb: 24'h0007C5};
      tbl[2]  = '{st: 8'h3C, d1: 8'h11, d2: 8'h22, n: 3'd0, eb: 24'h000000};
      tbl[3]  = '{st: 8'hE0, d1: 8'h7F, d2: 8'h80, n: 3'd3, eb: 24'h007FE0};
`ifdef MIDI_RUNNING_STATUS_EN
      tbl[4]  = '{st: 8'hE0, d1: 8'h01, d2: 8'h02, n: 3'd2, eb: 24'h000201};
      tbl[6]  = '{st: 8'hE0, d1: 8'h03, d2: 8'h04, n: 3'd2, eb: 24'h000403};
      tbl[15] = '{st: 8'hD2, d1: 8'hC1, d2: 8'h00, n: 3'd1, eb: 24'h000041};
`else
      tbl[4]  = '{st: 8'hE0, d1: 8'h01, d2: 8'h02, n: 3'd3, eb: 24'h0201E0};
      tbl[6]  = '{st: 8'hE0, d1: 8'h03, d2: 8'h04, n: 3'd3, eb: 24'h0403E0};
      tbl[15] = '{st: 8'hD2, d1: 8'hC1, d2: 8'h00, n: 3'd2, eb: 24'h0041D2};
`endif
      tbl[5]  = '{st: 8'hF8, d1: 8'h00, d2: 8'h00, n: 3'd1, eb: 24'h0000F8};
      tbl[7]  = '{st: 8'hF2, d1: 8'h05, d2: 8'h86, n: 3'd3, eb: 24'h0605F2};
      tbl[8]  = '{st: 8'hE0, d1: 8'h03, d2: 8'h04, n: 3'd3, eb: 24'h0403E0};
      tbl[9]  = '{st: 8'hF1, d1: 8'h11, d2: 8'h22, n: 3'd2, eb: 24'h0011F1};
      tbl[10] = '{st: 8'hF3, d1: 8'h09, d2: 8'hAA, n: 3'd2, eb: 24'h0009F3};
      tbl[11] = '{st: 8'hF6, d1: 8'h55, d2: 8'h66, n: 3'd1, eb: 24'h0000F6};
      tbl[12] = '{st: 8'hF0, d1: 8'h01, d2: 8'h02, n: 3'd1, eb: 24'h0000F0};
      tbl[13] = '{st: 8'hB0, d1: 8'h07, d2: 8'h7F, n: 3'd3, eb: 24'h7F07B0};
      tbl[14] = '{st: 8'hD2, d1: 8'h40, d2: 8'h00, n: 3'd2, eb: 24'h0040D2};
      tbl[16] = '{st: 8'h90, d1: 8'hBC, d2: 8'hE4, n: 3'd3, eb: 24'h643C90};
      tbl[17] = '{st: 8'h8F, d1: 8'h00, d2: 8'h7F, n: 3'd3, eb: 24'h7F008F};

      sel      = 1'b0;
      rst      = 1'b1;
      m_valid  = 1'b0;
      m_status = 8'h00;
      m_data1  = 8'h00;
      m_data2  = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      chk1("rst txd", s_txd, 1'b1);
      chk1("rst busy", s_busy, 1'b0);
      chk1("rst ready", s_ready, 1'b0);
      chk1("rst inv_txd", i_txd, 1'b0);
      chk1("rst inv_ready", i_ready, 1'b0);
      chk1("rst big_ready", b_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk1("release ready_before_edge", s_ready, 1'b0);
      @(posedge clk);
      #1;
      chk1("release ready", s_ready, 1'b1);
      chk1("release big_ready", b_ready, 1'b1);
      chk1("release inv_idle", i_txd, 1'b0);
      chk1("release inv_busy", i_busy, 1'b0);

      // Default-parameter instance: full-length bit period.
      sel = 1'b1;
      send_msg("note_on_default", 8'h90, 8'h3C, 8'h64, 3, 24'h643C90, DIV_B);
      sel = 1'b0;

      for (int i = 0; i < 18; i++) begin
         send_msg($sformatf("row%0d_%02h", i, tbl[i].st), tbl[i].st, tbl[i].d1, tbl[i].d2,
                  int'(tbl[i].n), tbl[i].eb, DIV_S);
         if (i == 2) chk1("discard inv_idle", i_txd, 1'b0);
      end

      // Reset in the middle of the 4th data bit of the first byte.
      @(negedge clk);
      m_status = 8'h90;
      m_data1  = 8'h3C;
      m_data2  = 8'h64;
      m_valid  = 1'b1;
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      repeat (4 * DIV_S + DIV_S / 2) @(posedge clk);
      #1;
      chk1("abort pre_line", s_txd, 1'b0);
      chk1("abort pre_busy", s_busy, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk1("abort txd", s_txd, 1'b1);
      chk1("abort busy", s_busy, 1'b0);
      chk1("abort ready", s_ready, 1'b0);
      chk1("abort inv_txd", i_txd, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk1("abort ready_before_edge", s_ready, 1'b0);
      @(posedge clk);
      #1;
      chk1("abort ready_after_edge", s_ready, 1'b1);
      send_msg("after_abort", 8'h90, 8'h12, 8'h34, 3, 24'h341290, DIV_S);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
